cdb_arbiter: RTL and testbench

- Shares a single common data bus between the adder and the multiplier functional units.
- Each FU result is pushed into a private FIFO.
- A round-robin arbiter pops one result per cycle and drives it, registered, onto the CDB.
- The CDB outputs feed the RAT and both reservation stations for tag match and value capture.

---
 rtl/cdb_arbiter.sv | 120 ++++++++++++
 tb/tb_cdb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares one common data bus between the adder and multiplier functional
//   units. Each FU result lands in a private FIFO; a round-robin arbiter pops
//   at most one head per cycle and registers it onto the CDB.
//
// Ports
//   clk, reset                    rising-edge clock, async active-low reset
//   add_valid/add_tag/add_data    adder result push
//   add_ready                     adder FIFO has room (count < DEPTH)
//   mul_valid/mul_tag/mul_data    multiplier result push
//   mul_ready                     multiplier FIFO has room
//   cdb_valid/cdb_tag/cdb_data    registered broadcast
//   cdb_src                       0 = adder, 1 = multiplier
//   add_count, mul_count          FIFO occupancies
module cdb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       add_valid,
  input  logic [TAG_W-1:0]           add_tag,
  input  logic [DATA_W-1:0]          add_data,
  output logic                       add_ready,
  input  logic                       mul_valid,
  input  logic [TAG_W-1:0]           mul_tag,
  input  logic [DATA_W-1:0]          mul_data,
  output logic                       mul_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       cdb_src,
  output logic [$clog2(DEPTH+1)-1:0] add_count,
  output logic [$clog2(DEPTH+1)-1:0] mul_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = TAG_W + DATA_W;

  typedef enum logic {
    SRC_ADD = 1'b0,
    SRC_MUL = 1'b1
  } src_e;

  logic [EW-1:0] add_mem [DEPTH];
  logic [EW-1:0] mul_mem [DEPTH];
  logic [PW-1:0] add_wr, add_rd, mul_wr, mul_rd;
  src_e          last_grant;

  logic add_push, mul_push, add_pop, mul_pop;
  logic add_ne, mul_ne;
  logic [EW-1:0] head;

  // Ready depends on count only, so a full FIFO refuses a push even in the
  // cycle it is popped.
  assign add_ready = (add_count != CW'(DEPTH));
  assign mul_ready = (mul_count != CW'(DEPTH));
  assign add_push  = add_valid && add_ready;
  assign mul_push  = mul_valid && mul_ready;

  assign add_ne = (add_count != '0);
  assign mul_ne = (mul_count != '0);

  // Round-robin: on conflict the source that did not win last time goes.
  always_comb begin
    add_pop = add_ne && (!mul_ne || last_grant == SRC_MUL);
    mul_pop = mul_ne && !add_pop;
    head    = add_pop ? add_mem[add_rd] : mul_mem[mul_rd];
  end

  // Storage needs no reset; pointers/counts define what is live.
  always_ff @(posedge clk) begin
    if (add_push) add_mem[add_wr] <= {add_tag, add_data};
    if (mul_push) mul_mem[mul_wr] <= {mul_tag, mul_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_wr     <= '0;
      add_rd     <= '0;
      mul_wr     <= '0;
      mul_rd     <= '0;
      add_count  <= '0;
      mul_count  <= '0;
      last_grant <= SRC_MUL;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
      cdb_src    <= 1'b0;
    end else begin
      if (add_push) add_wr <= add_wr + PW'(1);
      if (add_pop)  add_rd <= add_rd + PW'(1);
      if (mul_push) mul_wr <= mul_wr + PW'(1);
      if (mul_pop)  mul_rd <= mul_rd + PW'(1);

      case ({add_push, add_pop})
        2'b10:   add_count <= add_count + CW'(1);
        2'b01:   add_count <= add_count - CW'(1);
        default: add_count <= add_count;
      endcase
      case ({mul_push, mul_pop})
        2'b10:   mul_count <= mul_count + CW'(1);
        2'b01:   mul_count <= mul_count - CW'(1);
        default: mul_count <= mul_count;
      endcase

      cdb_valid <= add_pop || mul_pop;
      // Payload holds its last value when nothing is popped.
      if (add_pop || mul_pop) begin
        cdb_tag    <= head[EW-1:DATA_W];
        cdb_data   <= head[DATA_W-1:0];
        cdb_src    <= mul_pop;
        last_grant <= mul_pop ? SRC_MUL : SRC_ADD;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int VW     = 1 + TAG_W + DATA_W + 1 + CW + CW + 2;

  logic              clk;
  logic              reset;
  logic              add_valid, mul_valid;
  logic [TAG_W-1:0]  add_tag, mul_tag;
  logic [DATA_W-1:0] add_data, mul_data;
  logic              add_ready, mul_ready;
  logic              cdb_valid, cdb_src;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [CW-1:0]     add_count, mul_count;

  cdb_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .add_valid(add_valid), .add_tag(add_tag), .add_data(add_data), .add_ready(add_ready),
    .mul_valid(mul_valid), .mul_tag(mul_tag), .mul_data(mul_data), .mul_ready(mul_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .add_count(add_count), .mul_count(mul_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two queues of results and the broadcast register.
  typedef logic [TAG_W+DATA_W-1:0] ent_t;
  ent_t              aq[$];
  ent_t              mq[$];
  bit                m_last_mul;
  logic              e_valid, e_src;
  logic [TAG_W-1:0]  e_tag;
  logic [DATA_W-1:0] e_data;

  int checks = 0;
  int fails  = 0;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {cdb_valid, cdb_tag, cdb_data, cdb_src, add_count, mul_count, add_ready, mul_ready};

  function automatic logic [VW-1:0] exp_vec();
    return {e_valid, e_tag, e_data, e_src, CW'(aq.size()), CW'(mq.size()),
            aq.size() < DEPTH, mq.size() < DEPTH};
  endfunction

  task automatic model_clear();
    aq.delete();
    mq.delete();
    m_last_mul = 1'b1;
    e_valid = 1'b0; e_tag = '0; e_data = '0; e_src = 1'b0;
  endtask

  // Advance one rising edge; model evaluates the pre-edge state, then settle.
  task automatic step();
    bit pa, pm;
    ent_t h;
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      pa = add_valid && (aq.size() < DEPTH);
      pm = mul_valid && (mq.size() < DEPTH);
      if (aq.size() > 0 && (mq.size() == 0 || m_last_mul)) begin
        h = aq.pop_front();
        e_valid = 1'b1; e_src = 1'b0; m_last_mul = 1'b0;
        e_tag = h[TAG_W+DATA_W-1:DATA_W]; e_data = h[DATA_W-1:0];
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        e_valid = 1'b1; e_src = 1'b1; m_last_mul = 1'b1;
        e_tag = h[TAG_W+DATA_W-1:DATA_W]; e_data = h[DATA_W-1:0];
      end else begin
        e_valid = 1'b0;
      end
      if (pa) aq.push_back({add_tag, add_data});
      if (pm) mq.push_back({mul_tag, mul_data});
    end
    #1;
  endtask

  task automatic drive(input logic av, input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] ad,
                       input logic mv, input logic [TAG_W-1:0] mt, input logic [DATA_W-1:0] md);
    add_valid = av; add_tag = at; add_data = ad;
    mul_valid = mv; mul_tag = mt; mul_data = md;
  endtask

  task automatic test_reset();
    model_clear();
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      fails++; $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_vec());
    end
    step();
    #3 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec() || cdb_valid !== 1'b0) begin
        fails++; $display("FAIL idle_after_reset cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_contention();
    for (int r = 0; r < 2; r++) begin
      drive(1, 4'd2, 32'd5, 1, 4'd9, 32'd42);
      step();
      drive(0, '0, '0, 0, '0, '0);
      for (int i = 0; i < 3; i++) begin
        step();
        checks++;
        if (dut_vec !== exp_vec()) begin
          fails++; $display("FAIL contention r=%0d cyc=%0d got=%h exp=%h", r, i, dut_vec, exp_vec());
        end
        if (r == 0 && i < 2) begin
          checks++;
          if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== (i == 0 ? {1'b1, 1'b0, 4'd2, 32'd5}
                                                                  : {1'b1, 1'b1, 4'd9, 32'd42})) begin
            fails++; $display("FAIL contention_order cyc=%0d got v=%b s=%b t=%0d d=%0d",
                              i, cdb_valid, cdb_src, cdb_tag, cdb_data);
          end
        end
      end
    end
  endtask

  task automatic test_single();
    drive(1, 4'd3, 32'h10, 0, '0, '0);
    step();
    drive(0, '0, '0, 0, '0, '0);
    checks++;
    if (dut_vec !== exp_vec() || cdb_valid !== 1'b0) begin
      fails++; $display("FAIL single_push got=%h exp=%h", dut_vec, exp_vec());
    end
    step();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {1'b1, 4'd3, 32'h10, 1'b0} || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL single_bcast got=%h exp=%h", dut_vec, exp_vec());
    end
    step();
    checks++;
    if (cdb_valid !== 1'b0 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL single_idle got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_full();
    logic [TAG_W-1:0] at, mt;
    bit saw_full;
    at = 4'd1; mt = 4'd9; saw_full = 0;
    for (int i = 0; i < 14; i++) begin
      drive(1, at, 32'h100 + 32'(at), (mt <= 4'd12), mt, 32'h200 + 32'(mt));
      // Producer holds a result until the FIFO has room for it.
      if (aq.size() < DEPTH) at = at + 4'd1;
      if (mq.size() < DEPTH && mt <= 4'd12) mt = mt + 4'd1;
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL full_fill cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (add_count == CW'(DEPTH) && add_ready == 1'b0) saw_full = 1;
    end
    checks++;
    if (saw_full !== 1'b1) begin
      fails++; $display("FAIL full_reached got=%b exp=1", saw_full);
    end
    drive(0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL full_drain cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'(5 + i), 32'(i), 1, 4'(12 + i), 32'(100 + i));
      step();
    end
    drive(0, '0, '0, 0, '0, '0);
    checks++;
    if (dut_vec !== exp_vec() || cdb_valid !== 1'b1) begin
      fails++; $display("FAIL premid_state got=%h exp=%h", dut_vec, exp_vec());
    end
    #2 reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      fails++; $display("FAIL async_clear got=%h exp=%h", dut_vec, exp_vec());
    end
    step();
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec() || cdb_valid !== 1'b0) begin
        fails++; $display("FAIL no_stale cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
            1'($urandom_range(0, 2) != 0), 4'($urandom), $urandom);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    drive(0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, '0, '0, 0, '0, '0);
    test_reset();
    test_contention();
    test_single();
    test_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
